spi_cmd_receiver: RTL
=====================

SPI_CMD_RECEIVER -- requirements
Module: spi_cmd_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronisers on sclk, mosi, ss_n and latch_data; legal values 2 or 3.
REQ-002 clock  input  1  system clock (40 MHz nominal); all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sclk  input  1  SPI clock from the host; idles low; asynchronous to clock.
REQ-005 mosi  input  1  serial command data, MSB first; host changes it while sclk is low.
REQ-006 ss_n  input  1  active-low frame select.
REQ-007 latch_data  input  1  host commit pulse; a rising edge commits the held word.
REQ-008 miso  output  1  serial echo of the last committed word, MSB first.
REQ-009 driver_select  output  4  cmd[29:26].
REQ-010 mem_address  output  7  cmd[22:16].
REQ-011 update_mask  output  3  cmd[25:23].
REQ-012 wdata  output  16  cmd[15:0].
REQ-013 sel_row  output  7  cmd[21:15].
REQ-014 sel_col  output  7  cmd[14:8].
REQ-015 cfg_addr  output  6  cmd[21:16].
REQ-016 mem_we, dot_we, sel_we, cfg_we, ctrl_we  output  1 each  one-cycle write strobes.
REQ-017 frame_error, overrun  output  1 each  sticky error flags.

Function
REQ-018 sclk, mosi, ss_n and latch_data shall each pass through a SYNC_STAGES synchroniser; edges shall be detected only on synchronised copies.
REQ-019 The FSM shall have three states, IDLE, SHIFT and READY.
REQ-020 IDLE -> SHIFT on a synchronised ss_n falling edge; the bit counter shall clear and tx_shift shall load last_word.
REQ-021 In SHIFT, each synchronised sclk rising edge shall shift mosi into rx_shift[0] (left shift) and increment a 6-bit bit counter, saturating at 32.
REQ-022 In SHIFT, each synchronised sclk falling edge shall left-shift tx_shift; miso shall equal tx_shift[31] while ss_n is low and 0 otherwise.
REQ-023 On a synchronised ss_n rising edge in SHIFT: count == 32 -> hold_word <= rx_shift and go to READY; any other count -> set frame_error and go to IDLE.
REQ-024 More than 32 sclk edges in a frame shall keep only the last 32 bits and shall set frame_error at frame end.
REQ-025 A synchronised latch_data rising edge in READY shall decode hold_word, pulse exactly one strobe for one cycle on the next clock edge, copy hold_word to last_word, and return to IDLE.
REQ-026 A latch_data rising edge in IDLE or SHIFT shall be ignored and shall produce no strobe.
REQ-027 ss_n falling in READY shall discard hold_word, set overrun, and enter SHIFT.
REQ-028 The decode shall be:
- cmd[31:30]=00 -> mem_we
- 01 -> dot_we
- 10 with cmd[22]=1 -> sel_we
- 10 with cmd[22]=0 -> cfg_we
- 11 -> ctrl_we
REQ-029 All field outputs shall be registered from hold_word at the same edge as the strobe and shall hold until the next commit.
REQ-030 The latency from the first clock edge sampling latch_data=1 to the strobe high shall be exactly SYNC_STAGES+2 cycles.
REQ-031 frame_error and overrun shall clear only on reset or at a successful commit.

Reset
REQ-032 On reset assertion:
- FSM -> IDLE
- all shift registers, hold_word, last_word, the counter, all field outputs, all strobes, miso and the error flags -> 0
- synchronisers -> ss_n=1, others 0
REQ-033 A reset asserted mid-frame shall abort the frame with no strobe; after release, the next complete frame shall be received normally.

Verification
REQ-034 Frame 0x80000020 then a latch pulse -> cfg_we high for one cycle, cfg_addr=0, wdata=0x0020, all other strobes 0.
REQ-035 Frame 0x8C418202 then a latch pulse -> sel_we high, driver_select=3, sel_row=3, sel_col=2, wdata[7:0]=0x02.
REQ-036 Frame 0x1485FFFF then a latch pulse -> mem_we high, driver_select=5, update_mask=1, mem_address=5, wdata=0xFFFF; the next frame shifts 0x1485FFFF out on miso.
REQ-037 Frame 0xE0000000 then a latch pulse -> ctrl_we high, driver_select=4'b1000; a second latch pulse with no new frame -> no strobe.
REQ-038 20-bit frame then a latch pulse -> frame_error=1, no strobe; a following valid frame and latch pulse -> strobe, frame_error=0.
REQ-039 Two frames with no latch pulse between them, then a latch pulse -> overrun=1 set at the second ss_n fall; only the second word is decoded; reset asserted mid-frame -> all outputs 0.

Source files
------------

// File: rtl/spi_cmd_receiver_if.sv
// Host-facing bundle for the SPI command receiver: serial lines, commit
// pulse, decoded fields, write strobes and sticky error flags.
interface spi_cmd_receiver_if;
   logic        sclk;
   logic        mosi;
   logic        ss_n;
   logic        latch_data;
   logic        miso;
   logic [3:0]  driver_select;
   logic [6:0]  mem_address;
   logic [2:0]  update_mask;
   logic [15:0] wdata;
   logic [6:0]  sel_row;
   logic [6:0]  sel_col;
   logic [5:0]  cfg_addr;
   logic        mem_we;
   logic        dot_we;
   logic        sel_we;
   logic        cfg_we;
   logic        ctrl_we;
   logic        frame_error;
   logic        overrun;

   modport master (
      output sclk, mosi, ss_n, latch_data,
      input  miso, driver_select, mem_address, update_mask, wdata,
             sel_row, sel_col, cfg_addr,
             mem_we, dot_we, sel_we, cfg_we, ctrl_we,
             frame_error, overrun
   );

   modport slave (
      input  sclk, mosi, ss_n, latch_data,
      output miso, driver_select, mem_address, update_mask, wdata,
             sel_row, sel_col, cfg_addr,
             mem_we, dot_we, sel_we, cfg_we, ctrl_we,
             frame_error, overrun
   );
endinterface

// File: rtl/spi_cmd_receiver.sv
// Receives 32-bit SPI command frames, holds them until the host commits,
// then decodes the word into field registers and a single write strobe.
module spi_cmd_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input logic               clock,
   input logic               reset,
   spi_cmd_receiver_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, READY} state_t;

   state_t r_state;
   state_t w_nextState;

   logic [SYNC_STAGES-1:0] r_sclkSync, r_mosiSync, r_ssSync, r_latchSync;
   logic r_sclkPrev, r_ssPrev, r_latchPrev, r_latchRise;
   logic w_sclk, w_mosi, w_ss, w_latch;
   logic w_sclkRise, w_sclkFall, w_ssRise, w_ssFall, w_latchRise;

   logic [31:0] r_rxShift, r_txShift, r_holdWord, r_lastWord;
   logic [5:0]  r_bitCount;
   logic        r_extraBits, r_commit, r_miso, r_frameError, r_overrun;
   logic        w_startFrame, w_endGood, w_endBad, w_commit, w_overrunHit;

   logic [3:0]  r_driverSelect;
   logic [6:0]  r_memAddress, r_selRow, r_selCol;
   logic [2:0]  r_updateMask;
   logic [15:0] r_wdata;
   logic [5:0]  r_cfgAddr;
   logic        r_memWe, r_dotWe, r_selWe, r_cfgWe, r_ctrlWe;

   assign w_sclk  = r_sclkSync[SYNC_STAGES-1];
   assign w_mosi  = r_mosiSync[SYNC_STAGES-1];
   assign w_ss    = r_ssSync[SYNC_STAGES-1];
   assign w_latch = r_latchSync[SYNC_STAGES-1];

   assign w_sclkRise  = w_sclk & ~r_sclkPrev;
   assign w_sclkFall  = ~w_sclk & r_sclkPrev;
   assign w_ssRise    = w_ss & ~r_ssPrev;
   assign w_ssFall    = ~w_ss & r_ssPrev;
   assign w_latchRise = w_latch & ~r_latchPrev;

   // The latch edge gets one extra register so commit latency is SYNC_STAGES+2.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sclkSync  <= '0;
         r_mosiSync  <= '0;
         r_ssSync    <= '1;
         r_latchSync <= '0;
         r_sclkPrev  <= 1'b0;
         r_ssPrev    <= 1'b1;
         r_latchPrev <= 1'b0;
         r_latchRise <= 1'b0;
      end else begin
         r_sclkSync  <= {r_sclkSync[SYNC_STAGES-2:0], bus.sclk};
         r_mosiSync  <= {r_mosiSync[SYNC_STAGES-2:0], bus.mosi};
         r_ssSync    <= {r_ssSync[SYNC_STAGES-2:0], bus.ss_n};
         r_latchSync <= {r_latchSync[SYNC_STAGES-2:0], bus.latch_data};
         r_sclkPrev  <= w_sclk;
         r_ssPrev    <= w_ss;
         r_latchPrev <= w_latch;
         r_latchRise <= w_latchRise;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState  = r_state;
      w_startFrame = 1'b0;
      w_endGood    = 1'b0;
      w_endBad     = 1'b0;
      w_commit     = 1'b0;
      w_overrunHit = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ssFall) begin
               w_startFrame = 1'b1;
               w_nextState  = SHIFT;
            end
         end
         SHIFT: begin
            if (w_ssRise) begin
               if (r_bitCount == 6'd32 && !r_extraBits) begin
                  w_endGood   = 1'b1;
                  w_nextState = READY;
               end else begin
                  w_endBad    = 1'b1;
                  w_nextState = IDLE;
               end
            end
         end
         READY: begin
            if (w_ssFall) begin
               w_overrunHit = 1'b1;
               w_startFrame = 1'b1;
               w_nextState  = SHIFT;
            end else if (r_latchRise) begin
               w_commit    = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Counter saturates at 32; any further sclk edge marks the frame as too long.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rxShift    <= '0;
         r_txShift    <= '0;
         r_holdWord   <= '0;
         r_bitCount   <= '0;
         r_extraBits  <= 1'b0;
         r_commit     <= 1'b0;
         r_miso       <= 1'b0;
         r_frameError <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_commit <= w_commit;
         if (w_startFrame) begin
            r_rxShift   <= '0;
            r_bitCount  <= '0;
            r_extraBits <= 1'b0;
            r_txShift   <= r_lastWord;
         end else if (r_state == SHIFT) begin
            if (w_sclkRise) begin
               r_rxShift <= {r_rxShift[30:0], w_mosi};
               if (r_bitCount == 6'd32) r_extraBits <= 1'b1;
               else                     r_bitCount  <= r_bitCount + 6'd1;
            end
            if (w_sclkFall) r_txShift <= {r_txShift[30:0], 1'b0};
         end
         if (w_endGood)         r_holdWord <= r_rxShift;
         else if (w_overrunHit) r_holdWord <= '0;
         r_miso <= w_ss ? 1'b0 : r_txShift[31];
         if (w_endBad)      r_frameError <= 1'b1;
         else if (r_commit) r_frameError <= 1'b0;
         if (w_overrunHit)  r_overrun <= 1'b1;
         else if (r_commit) r_overrun <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_lastWord     <= '0;
         r_driverSelect <= '0;
         r_memAddress   <= '0;
         r_updateMask   <= '0;
         r_wdata        <= '0;
         r_selRow       <= '0;
         r_selCol       <= '0;
         r_cfgAddr      <= '0;
         r_memWe        <= 1'b0;
         r_dotWe        <= 1'b0;
         r_selWe        <= 1'b0;
         r_cfgWe        <= 1'b0;
         r_ctrlWe       <= 1'b0;
      end else begin
         r_memWe  <= 1'b0;
         r_dotWe  <= 1'b0;
         r_selWe  <= 1'b0;
         r_cfgWe  <= 1'b0;
         r_ctrlWe <= 1'b0;
         if (r_commit) begin
            r_lastWord     <= r_holdWord;
            r_driverSelect <= r_holdWord[29:26];
            r_memAddress   <= r_holdWord[22:16];
            r_updateMask   <= r_holdWord[25:23];
            r_wdata        <= r_holdWord[15:0];
            r_selRow       <= r_holdWord[21:15];
            r_selCol       <= r_holdWord[14:8];
            r_cfgAddr      <= r_holdWord[21:16];
            case (r_holdWord[31:30])
               2'b00:   r_memWe  <= 1'b1;
               2'b01:   r_dotWe  <= 1'b1;
               2'b10:   begin
                  if (r_holdWord[22]) r_selWe <= 1'b1;
                  else                r_cfgWe <= 1'b1;
               end
               default: r_ctrlWe <= 1'b1;
            endcase
         end
      end
   end

   assign bus.miso          = r_miso;
   assign bus.driver_select = r_driverSelect;
   assign bus.mem_address   = r_memAddress;
   assign bus.update_mask   = r_updateMask;
   assign bus.wdata         = r_wdata;
   assign bus.sel_row       = r_selRow;
   assign bus.sel_col       = r_selCol;
   assign bus.cfg_addr      = r_cfgAddr;
   assign bus.mem_we        = r_memWe;
   assign bus.dot_we        = r_dotWe;
   assign bus.sel_we        = r_selWe;
   assign bus.cfg_we        = r_cfgWe;
   assign bus.ctrl_we       = r_ctrlWe;
   assign bus.frame_error   = r_frameError;
   assign bus.overrun       = r_overrun;

endmodule
